// File: rtl/run_controller_pkg.sv
// Shared types and constants for the MIPS run/halt/step sequencer.
package run_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } run_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'd0,
    CAUSE_REQ   = 2'd1,
    CAUSE_BP    = 2'd2,
    CAUSE_INSTR = 2'd3
  } halt_cause_t;

  localparam logic [5:0]  OP_HALT           = 6'h3F;
  localparam logic [31:0] DEFAULT_HALT_WORD = {OP_HALT, 26'd0};

endpackage

// File: rtl/run_controller_if.sv
// Control/debug signal bundle between the debug harness and the run controller.
interface run_controller_if #(
  parameter int unsigned WL = 32,
  parameter int unsigned CW = 32
);
  logic          run_req;
  logic          halt_req;
  logic          step_req;
  logic          bp_en;
  logic [WL-1:0] bp_addr;
  logic [WL-1:0] PC_curr;
  logic [WL-1:0] Inst;
  logic          CPU_EN;
  logic [1:0]    state;
  logic [1:0]    halt_cause;
  logic [CW-1:0] instr_count;

  modport master (
    output run_req, halt_req, step_req, bp_en, bp_addr, PC_curr, Inst,
    input  CPU_EN, state, halt_cause, instr_count
  );

  modport slave (
    input  run_req, halt_req, step_req, bp_en, bp_addr, PC_curr, Inst,
    output CPU_EN, state, halt_cause, instr_count
  );
endinterface

// File: rtl/run_controller_sat_counter.sv
// Saturating up-counter: increments on inc, holds at all-ones.
module sat_counter #(
  parameter int unsigned CW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          inc,
  output logic [CW-1:0] count
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/run_controller.sv
// Run/halt/step sequencer producing CPU_EN for the single-cycle MIPS datapath,
// with PC breakpoint, halt-instruction detection and retired-instruction counter.
module run_controller
  import run_controller_pkg::*;
#(
  parameter int unsigned   WL        = 32,
  parameter int unsigned   CW        = 32,
  parameter logic [WL-1:0] HALT_WORD = WL'(DEFAULT_HALT_WORD)
) (
  input  logic             CLK,
  input  logic             RST,
  run_controller_if.slave  bus
);

  run_state_t  state_q, state_d;
  halt_cause_t cause_q, cause_d;
  logic        bp_skip_q, bp_skip_d;
  logic        bp_hit, halt_hit, cpu_en;
  logic [CW-1:0] count;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cause_q   <= CAUSE_NONE;
      bp_skip_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      bp_skip_q <= bp_skip_d;
    end
  end

  always_comb begin
    bp_hit    = bus.bp_en && (bus.PC_curr == bus.bp_addr) && !bp_skip_q;
    halt_hit  = (bus.Inst == HALT_WORD);
    cpu_en    = 1'b0;
    state_d   = state_q;
    cause_d   = cause_q;
    bp_skip_d = bp_skip_q;

    unique case (state_q)
      ST_RUN: begin
        cpu_en = !(bp_hit || halt_hit || bus.halt_req);
        if (bus.halt_req) begin
          state_d = ST_HALT;
          cause_d = CAUSE_REQ;
        end else if (halt_hit) begin
          state_d = ST_HALT;
          cause_d = CAUSE_INSTR;
        end else if (bp_hit) begin
          state_d = ST_HALT;
          cause_d = CAUSE_BP;
        end
      end
      ST_STEP: begin
        // A halt word is never committed, even when single-stepping onto it.
        cpu_en  = !halt_hit;
        state_d = ST_HALT;
        cause_d = halt_hit ? CAUSE_INSTR : CAUSE_REQ;
      end
      default: begin
        // IDLE/HALT: a halt instruction locks the core until reset.
        if ((cause_q != CAUSE_INSTR) && !bus.halt_req) begin
          if (bus.step_req) begin
            state_d   = ST_STEP;
            cause_d   = CAUSE_NONE;
            bp_skip_d = 1'b1;
          end else if (bus.run_req) begin
            state_d   = ST_RUN;
            cause_d   = CAUSE_NONE;
            bp_skip_d = 1'b1;
          end
        end
      end
    endcase

    if (cpu_en) begin
      bp_skip_d = 1'b0;
    end
  end

  sat_counter #(.CW(CW)) u_instr_count (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (cpu_en),
    .count (count)
  );

  assign bus.CPU_EN      = cpu_en;
  assign bus.state       = state_q;
  assign bus.halt_cause  = cause_q;
  assign bus.instr_count = count;

endmodule
